// File: rtl/game_flow_ctrl.sv
// Game-level flow FSM: start / play / dying / game-over sequencing, BCD score and
// high score keeping, and re-arming of the collision checker while idle.
module game_flow_ctrl #(
  parameter int unsigned DEATH_FRAMES = 60
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        alive,
  input  logic        flap,
  input  logic        pipe_passed,
  output logic [1:0]  state,
  output logic        scroll_en,
  output logic        bird_frozen,
  output logic        checker_rst_n,
  output logic        game_over,
  output logic [11:0] score,
  output logic [11:0] high_score
);

  localparam int unsigned CntW = $clog2(DEATH_FRAMES + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPlay  = 2'd1,
    StDying = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              flap_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       score_q, score_d;
  logic [11:0]       high_q, high_d;
  logic [11:0]       score_inc;
  logic              flap_rise;
  logic              cnt_done;

  assign flap_rise = flap & ~flap_q;
  assign cnt_done  = (cnt_q == CntW'(DEATH_FRAMES));

  // Packed-BCD increment with digit carry; saturates at 999.
  always_comb begin
    score_inc = score_q;
    if (score_q != 12'h999) begin
      if (score_q[3:0] != 4'd9) begin
        score_inc[3:0] = score_q[3:0] + 4'd1;
      end else begin
        score_inc[3:0] = 4'd0;
        if (score_q[7:4] != 4'd9) begin
          score_inc[7:4] = score_q[7:4] + 4'd1;
        end else begin
          score_inc[7:4]  = 4'd0;
          score_inc[11:8] = score_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (flap_rise) begin
          state_d = StPlay;
          score_d = 12'h000;
        end
      end
      StPlay: begin
        // Death takes priority over a coincident pipe pass.
        if (!alive) begin
          state_d = StDying;
        end else if (pipe_passed) begin
          score_d = score_inc;
        end
      end
      StDying: begin
        if (cnt_done) begin
          state_d = StOver;
          cnt_d   = '0;
          // Packed BCD orders the same as the numeric value.
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end else if (frame_tick) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StOver: begin
        if (flap_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      score_q <= 12'h000;
      high_q  <= 12'h000;
      cnt_q   <= '0;
      flap_q  <= 1'b1;  // a button held through reset must not start a game
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      cnt_q   <= cnt_d;
      flap_q  <= flap;
    end
  end

  assign state         = state_q;
  assign scroll_en     = (state_q == StPlay);
  assign bird_frozen   = (state_q == StIdle) || (state_q == StOver);
  assign checker_rst_n = (state_q != StIdle);
  assign game_over     = (state_q == StOver);
  assign score         = score_q;
  assign high_score    = high_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus a randomized run,
// all checked against a decimal-integer reference model of the game rules.
module tb_game_flow_ctrl;

  localparam int unsigned DF = 4;

  logic        clk;
  logic        rst_n;
  logic        frame_tick, alive, flap, pipe_passed;
  logic [1:0]  state;
  logic        scroll_en, bird_frozen, checker_rst_n, game_over;
  logic [11:0] score, high_score;

  int total = 0;
  int bad   = 0;

  // Reference model: state as 0..3, scores as plain decimal integers.
  int m_state, m_score, m_high, m_cnt;
  bit m_fq;

  game_flow_ctrl #(.DEATH_FRAMES(DF)) dut (
    .clk           (clk),
    .Reset         (rst_n),
    .frame_tick    (frame_tick),
    .alive         (alive),
    .flap          (flap),
    .pipe_passed   (pipe_passed),
    .state         (state),
    .scroll_en     (scroll_en),
    .bird_frozen   (bird_frozen),
    .checker_rst_n (checker_rst_n),
    .game_over     (game_over),
    .score         (score),
    .high_score    (high_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [29:0] exp_vec();
    return {2'(m_state), m_state == 1, (m_state == 0) || (m_state == 3), m_state != 0,
            m_state == 3, to_bcd(m_score), to_bcd(m_high)};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {state, scroll_en, bird_frozen, checker_rst_n, game_over, score, high_score};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle 1 time unit.
  task automatic cyc(input bit r, input bit ft, input bit al, input bit fl, input bit pp);
    bit rise;
    rst_n = r; frame_tick = ft; alive = al; flap = fl; pipe_passed = pp;
    @(posedge clk);
    if (!r) begin
      m_state = 0; m_score = 0; m_high = 0; m_cnt = 0; m_fq = 1'b1;
    end else begin
      rise = fl && !m_fq;
      case (m_state)
        0: if (rise) begin m_state = 1; m_score = 0; end
        1: if (!al) m_state = 2;
           else if (pp && m_score < 999) m_score++;
        2: if (m_cnt == DF) begin
             m_state = 3; m_cnt = 0;
             if (m_score > m_high) m_high = m_score;
           end else if (ft) m_cnt++;
        default: if (rise) m_state = 0;
      endcase
      m_fq = fl;
    end
    #1;
  endtask

  task automatic start_game();
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 0);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 0, 1);
  endtask

  task automatic ticks(input int n, input bit fl);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 1, fl, 0);
      cyc(1, 1, 1, fl, 0);
    end
  endtask

  task automatic test_reset();
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 1, 1, 0);
    total++;
    if (state !== 2'd0 || checker_rst_n !== 1'b0) begin
      bad++; $display("FAIL reset_held_flap: state=%0d crst=%0b want state=0 crst=0",
                      state, checker_rst_n);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_vec: got %h want %h", dut_vec(), exp_vec());
    end
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    total++;
    if (state !== 2'd1 || score !== 12'h000 || checker_rst_n !== 1'b1 || scroll_en !== 1'b1) begin
      bad++; $display("FAIL start: state=%0d score=%h crst=%0b scroll=%0b want 1 000 1 1",
                      state, score, checker_rst_n, scroll_en);
    end
  endtask

  task automatic test_score_and_death();
    pulses(12);
    total++;
    if (score !== 12'h012) begin
      bad++; $display("FAIL score_12: got %h want 012", score);
    end
    cyc(1, 0, 0, 0, 0);
    total++;
    if (state !== 2'd2 || scroll_en !== 1'b0 || bird_frozen !== 1'b0) begin
      bad++; $display("FAIL die: state=%0d scroll=%0b frozen=%0b want 2 0 0",
                      state, scroll_en, bird_frozen);
    end
    cyc(1, 0, 1, 0, 1);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL alive_return: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_death_wins();
    cyc(0, 0, 1, 0, 0);
    start_game();
    pulses(7);
    cyc(1, 0, 0, 0, 1);
    total++;
    if (score !== 12'h007 || state !== 2'd2) begin
      bad++; $display("FAIL death_wins: score=%h state=%0d want 007 2", score, state);
    end
  endtask

  task automatic test_high_score();
    cyc(0, 0, 1, 0, 0);
    start_game();
    pulses(12);
    cyc(1, 0, 0, 0, 0);
    ticks(DF, 1'b0);
    total++;
    if (state !== 2'd2) begin
      bad++; $display("FAIL dying_after_ticks: state=%0d want 2", state);
    end
    cyc(1, 0, 1, 0, 0);
    total++;
    if (state !== 2'd3 || high_score !== 12'h012 || game_over !== 1'b1) begin
      bad++; $display("FAIL over_high: state=%0d high=%h go=%0b want 3 012 1",
                      state, high_score, game_over);
    end
    cyc(1, 0, 1, 1, 0);
    total++;
    if (state !== 2'd0 || score !== 12'h012) begin
      bad++; $display("FAIL over_to_idle: state=%0d score=%h want 0 012", state, score);
    end
    start_game();
    pulses(5);
    cyc(1, 0, 0, 0, 0);
    ticks(DF, 1'b0);
    cyc(1, 0, 1, 0, 0);
    total++;
    if (state !== 2'd3 || high_score !== 12'h012 || score !== 12'h005) begin
      bad++; $display("FAIL high_kept: state=%0d high=%h score=%h want 3 012 005",
                      state, high_score, score);
    end
  endtask

  task automatic test_saturate();
    cyc(0, 0, 1, 0, 0);
    start_game();
    pulses(99);
    total++;
    if (score !== 12'h099) begin
      bad++; $display("FAIL score_99: got %h want 099", score);
    end
    pulses(1);
    total++;
    if (score !== 12'h100) begin
      bad++; $display("FAIL carry_100: got %h want 100", score);
    end
    pulses(905);
    total++;
    if (score !== 12'h999) begin
      bad++; $display("FAIL saturate: got %h want 999", score);
    end
    pulses(3);
    total++;
    if (score !== 12'h999) begin
      bad++; $display("FAIL sat_hold: got %h want 999", score);
    end
  endtask

  task automatic test_reset_mid_and_held_flap();
    cyc(0, 0, 1, 0, 0);
    start_game();
    pulses(12);
    cyc(1, 0, 0, 0, 0);
    ticks(DF, 1'b0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    start_game();
    pulses(3);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    total++;
    if (state !== 2'd0 || score !== 12'h000 || high_score !== 12'h000) begin
      bad++; $display("FAIL reset_mid: state=%0d score=%h high=%h want 0 000 000",
                      state, score, high_score);
    end
    start_game();
    pulses(2);
    cyc(1, 0, 0, 1, 0);
    ticks(DF + 2, 1'b1);
    total++;
    if (state !== 2'd3) begin
      bad++; $display("FAIL held_into_over: state=%0d want 3", state);
    end
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 0);
    total++;
    if (state !== 2'd0) begin
      bad++; $display("FAIL repress_idle: state=%0d want 0", state);
    end
  endtask

  task automatic test_random();
    bit r, ft, al, fl, pp;
    fl = 1'b0;
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 599) != 0);
      ft = ($urandom_range(0, 2) == 0);
      al = ($urandom_range(0, 39) != 0);
      pp = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) fl = ~fl;
      cyc(r, ft, al, fl, pp);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; alive = 1'b1; flap = 1'b0; pipe_passed = 1'b0;
    m_state = 0; m_score = 0; m_high = 0; m_cnt = 0; m_fq = 1'b1;
    test_reset();
    test_score_and_death();
    test_death_wins();
    test_high_score();
    test_saturate();
    test_reset_mid_and_held_flap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
